x_alp_status_indicator: RTL and testbench
=========================================

X_ALP_STATUS_INDICATOR -- requirements
Module: x_alp_status_indicator

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of indicator LED channels (1..16).
REQ-002 SHALL have parameter DIV, default 62500000, clock cycles per tick (>=2).
REQ-003 SHALL have parameter GAP_TICKS, default 4, off-ticks between exit-code pulse trains (>=1).
REQ-004 SHALL have parameter CODE_W, default 4, exit-value LSBs shown as a pulse count (1..8).
REQ-005 SHALL have parameter EXIT_W, default 32, exit value width.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port mode_i  input  2*NUM_LEDS  per-LED mode; LED k uses bits [2k+1:2k]; 0 OFF, 1 ON, 2 HEARTBEAT, 3 EXIT.
REQ-009 SHALL have port exit_valid_i  input  1  exit event strobe from the SoC.
REQ-010 SHALL have port exit_value_i  input  EXIT_W  exit value, sampled when exit_valid_i=1.
REQ-011 SHALL have port led_o  output  NUM_LEDS  registered LED drive, 1 = lit.
REQ-012 SHALL have port tick_o  output  1  one-cycle prescaler tick pulse.
REQ-013 SHALL have port exit_latched_o  output  1  high once an exit has been captured.
REQ-014 SHALL have port exit_value_o  output  EXIT_W  captured exit value.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap; tick_o=1 exactly in the cycle count==DIV-1, so the period is DIV cycles.
REQ-016 Heartbeat bit hb SHALL toggle on every tick, giving a square wave of period 2*DIV.
REQ-017 The first exit_valid_i=1 after reset SHALL capture exit_value_i into exit_value_o and set exit_latched_o on the next edge; later strobes SHALL be ignored until reset.
REQ-018 Pulse count N SHALL be exit_value[CODE_W-1:0], except N=2^CODE_W when those bits are 0 and the value is nonzero; the counter is CODE_W+1 bits.
REQ-019 Exit FSM states SHALL be IDLE, PASS, GAP, P_ON, P_OFF.
REQ-020 IDLE SHALL go on capture to PASS if the captured value==0, otherwise to GAP with gap counter=0 and pulse counter=0.
REQ-021 PASS SHALL be terminal until reset.
REQ-022 GAP SHALL advance its counter on each tick and go to P_ON on the tick that completes GAP_TICKS ticks.
REQ-023 P_ON SHALL go to P_OFF on the next tick and increment the pulse counter.
REQ-024 P_OFF SHALL go on the next tick to GAP (clearing both counters) if pulse counter==N, otherwise to P_ON.
REQ-025 If a capture coincides with tick_o, the capture SHALL take effect, the FSM SHALL ignore that tick, and the prescaler SHALL still count.
REQ-026 led_o[k] SHALL register per mode: OFF 0, ON 1, HEARTBEAT hb; EXIT gives hb in IDLE, 1 in PASS and P_ON, 0 in GAP and P_OFF.
REQ-027 mode_i changes SHALL take effect on led_o one cycle later, with no effect on FSM, prescaler or hb.
REQ-028 led_o latency from any state, hb or mode change SHALL be exactly 1 cycle.

Reset
REQ-029 With rst_i=1 at an edge, next-cycle values SHALL be: prescaler 0, hb 0, FSM IDLE, counters 0, led_o 0, tick_o 0, exit_latched_o 0, exit_value_o 0.
REQ-030 Reset asserted mid-pattern SHALL abort the pattern with the values of REQ-029 and allow a new capture afterwards.
REQ-031 Reset SHALL take priority over exit_valid_i and tick in the same cycle.

Verification (DIV=4, GAP_TICKS=2, CODE_W=3, NUM_LEDS=2)
REQ-032 Reset release, mode_i=all HEARTBEAT -> tick_o high at cycles 3, 7, 11; led_o=2'b11 during cycles 4..7; led_o=0 during cycles 8..11.
REQ-033 exit_value=0 strobe, LED0 in EXIT mode -> exit_latched_o=1 and led_o[0]=1 from one cycle later, steady for 100 cycles.
REQ-034 exit_value=3 strobe -> each repeating frame is 2 off ticks, then 3 cycles of (1 tick on, 1 tick off), 32 clocks total.
REQ-035 exit_value=0x10 (low bits 0, nonzero) -> 8 pulses per frame; a second strobe with value 5 -> exit_value_o stays 0x10.
REQ-036 Strobe on the same cycle as tick_o -> value captured, FSM enters GAP, first gap tick is the following tick.
REQ-037 rst_i pulsed during P_ON -> all outputs 0 next cycle; a new strobe with value 1 then yields 1 pulse per frame.

Source files
------------

// File: rtl/x_alp_status_indicator.sv
// Board status LEDs: off/on/heartbeat per channel, plus an exit-code display that
// latches the first SoC exit value and blinks its low bits as a repeating pulse train.
module x_alp_status_indicator #(
  parameter int NUM_LEDS  = 4,
  parameter int DIV       = 62500000,
  parameter int GAP_TICKS = 4,
  parameter int CODE_W    = 4,
  parameter int EXIT_W    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*NUM_LEDS-1:0] mode_i,
  input  logic                  exit_valid_i,
  input  logic [EXIT_W-1:0]     exit_value_i,
  output logic [NUM_LEDS-1:0]   led_o,
  output logic                  tick_o,
  output logic                  exit_latched_o,
  output logic [EXIT_W-1:0]     exit_value_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_HB   = 2'd2;
  localparam logic [1:0] MODE_EXIT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_GAP,
    S_P_ON,
    S_P_OFF
  } state_t;

  logic [CNT_W-1:0]  cnt_reg;
  logic              hb_reg;
  logic              hb_next;
  logic              tick;
  logic              latched_reg;
  logic [EXIT_W-1:0] value_reg;
  logic              capture;
  state_t            state_reg, state_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [CODE_W:0]   pulse_reg, pulse_next;
  logic [CODE_W:0]   n_pulses;
  logic              exit_led;
  logic [NUM_LEDS-1:0] led_next;
  logic [NUM_LEDS-1:0] led_reg;

  assign tick    = (cnt_reg == CNT_MAX);
  assign hb_next = tick ? ~hb_reg : hb_reg;
  assign capture = exit_valid_i & ~latched_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
      hb_reg  <= 1'b0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
      hb_reg  <= hb_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      latched_reg <= 1'b0;
      value_reg   <= '0;
    end else if (capture) begin
      latched_reg <= 1'b1;
      value_reg   <= exit_value_i;
    end
  end

  // A zero code field on a nonzero value means a full 2^CODE_W pulses.
  assign n_pulses = (value_reg[CODE_W-1:0] == '0) ? {1'b1, {CODE_W{1'b0}}}
                                                 : {1'b0, value_reg[CODE_W-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      gap_reg   <= '0;
      pulse_reg <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      pulse_reg <= pulse_next;
    end
  end

  // IDLE never looks at the tick, so a capture landing on a tick drops that tick.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    pulse_next = pulse_reg;
    case (state_reg)
      S_IDLE: begin
        if (capture) begin
          state_next = (exit_value_i == '0) ? S_PASS : S_GAP;
          gap_next   = '0;
          pulse_next = '0;
        end
      end
      S_PASS: state_next = S_PASS;
      S_GAP: begin
        if (tick) begin
          gap_next = gap_reg + GAP_W'(1);
          if (gap_reg == GAP_LAST) state_next = S_P_ON;
        end
      end
      S_P_ON: begin
        if (tick) begin
          state_next = S_P_OFF;
          pulse_next = pulse_reg + (CODE_W+1)'(1);
        end
      end
      S_P_OFF: begin
        if (tick) begin
          if (pulse_reg == n_pulses) begin
            state_next = S_GAP;
            gap_next   = '0;
            pulse_next = '0;
          end else begin
            state_next = S_P_ON;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // LEDs are built from next-state values so they line up with the state registers.
  always_comb begin
    exit_led = 1'b0;
    case (state_next)
      S_IDLE:         exit_led = hb_next;
      S_PASS, S_P_ON: exit_led = 1'b1;
      default:        exit_led = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic [1:0] mode;
      assign mode = mode_i[2*gi +: 2];
      assign led_next[gi] = (mode == MODE_ON)
                          | ((mode == MODE_HB) & hb_next)
                          | ((mode == MODE_EXIT) & exit_led);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) led_reg <= '0;
    else       led_reg <= led_next;
  end

  assign led_o          = led_reg;
  assign tick_o         = tick;
  assign exit_latched_o = latched_reg;
  assign exit_value_o   = value_reg;

endmodule

// File: tb/tb_x_alp_status_indicator.sv
// Randomized bench for x_alp_status_indicator; expected LED/tick/exit outputs come from
// tick-count arithmetic on the cycle number since reset and the captured exit value.
module tb_x_alp_status_indicator;

  localparam int NL = 2;
  localparam int DV = 4;
  localparam int GT = 2;
  localparam int CW = 3;
  localparam int EW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [2*NL-1:0] mode_i = '0;
  logic            exit_valid_i = 1'b0;
  logic [EW-1:0]   exit_value_i = '0;
  logic [NL-1:0]   led_o;
  logic            tick_o;
  logic            exit_latched_o;
  logic [EW-1:0]   exit_value_o;

  x_alp_status_indicator #(
    .NUM_LEDS(NL), .DIV(DV), .GAP_TICKS(GT), .CODE_W(CW), .EXIT_W(EW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .mode_i(mode_i),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .led_o(led_o),
    .tick_o(tick_o),
    .exit_latched_o(exit_latched_o),
    .exit_value_o(exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [2*NL-1:0] mode_prev = '0;
  logic          m_captured = 1'b0;
  int            m_cap_cycle = 0;
  logic [EW-1:0] m_cap_val = '0;

  // Heartbeat level = parity of the number of ticks completed before cycle c.
  function automatic logic m_hb(int c);
    return ((c / DV) % 2) == 1;
  endfunction

  function automatic logic m_tick(int c);
    return (c % DV) == DV - 1;
  endfunction

  function automatic logic m_exit(int c);
    int n, f, m, pos;
    if (!m_captured || c <= m_cap_cycle) return m_hb(c);
    if (m_cap_val == 0) return 1'b1;
    n = int'(m_cap_val % EW'(1 << CW));
    if (n == 0) n = 1 << CW;
    f = GT + 2 * n;
    m = c / DV - (m_cap_cycle + 1) / DV;
    pos = m % f;
    if (pos < GT) return 1'b0;
    return ((pos - GT) % 2) == 0;
  endfunction

  function automatic logic [NL-1:0] m_led(int c, logic [2*NL-1:0] md);
    logic [NL-1:0] r;
    logic [2*NL-1:0] mv;
    r  = '0;
    mv = md;
    for (int k = 0; k < NL; k++) begin
      case (mv[2*k +: 2])
        2'd0:    r[k] = 1'b0;
        2'd1:    r[k] = 1'b1;
        2'd2:    r[k] = m_hb(c);
        default: r[k] = m_exit(c);
      endcase
    end
    if (c == 0) r = '0;
    return r;
  endfunction

  task automatic drive(input logic [2*NL-1:0] md, input logic v, input logic [EW-1:0] val);
    mode_prev    = mode_i;
    mode_i       = md;
    exit_valid_i = v;
    exit_value_i = val;
    if (v && !m_captured) begin
      m_captured  = 1'b1;
      m_cap_cycle = cyc;
      m_cap_val   = val;
      $display("capture cyc=%0d value=0x%0h", cyc, val);
    end else if (v) begin
      $display("ignored strobe cyc=%0d value=0x%0h held=0x%0h", cyc, val, m_cap_val);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Reset cycle also carries an exit strobe, which must lose to reset.
  task automatic do_reset();
    rst_i        = 1'b1;
    exit_valid_i = 1'b1;
    exit_value_i = $urandom;
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    exit_valid_i = 1'b0;
    cyc          = 0;
    m_captured   = 1'b0;
    m_cap_val    = '0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'b0101, 1'b0, '0);
    @(negedge clk_i);
    n_cmp++; if (led_o !== '0) begin n_fail++; $display("FAIL reset_led got=%b exp=00", led_o); end
    n_cmp++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick_o); end
    n_cmp++; if (exit_latched_o !== 1'b0) begin n_fail++; $display("FAIL reset_latched got=%b exp=0", exit_latched_o); end
    n_cmp++; if (exit_value_o !== '0) begin n_fail++; $display("FAIL reset_value got=0x%0h exp=0", exit_value_o); end
    advance();
    drive(4'b0101, 1'b0, '0);
    @(negedge clk_i);
    n_cmp++; if (led_o !== 2'b11) begin n_fail++; $display("FAIL reset_on_mode got=%b exp=11", led_o); end
    advance();
  endtask

  task automatic test_heartbeat();
    logic [NL-1:0] exp_led;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(4'b1010, 1'b0, $urandom);
      @(negedge clk_i);
      exp_led = m_led(cyc, mode_prev);
      n_cmp++;
      if (tick_o !== m_tick(cyc)) begin
        n_fail++; $display("FAIL hb_tick cyc=%0d got=%b exp=%b", cyc, tick_o, m_tick(cyc));
      end
      n_cmp++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL hb_led cyc=%0d got=%b exp=%b", cyc, led_o, exp_led);
      end
      advance();
    end
  endtask

  task automatic test_modes();
    logic [NL-1:0] exp_led;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      drive(4'($urandom), 1'b0, $urandom);
      @(negedge clk_i);
      exp_led = m_led(cyc, mode_prev);
      n_cmp++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL mode_led cyc=%0d got=%b exp=%b", cyc, led_o, exp_led);
      end
      advance();
    end
  endtask

  task automatic test_exit_pass();
    int t;
    logic [NL-1:0] exp_led;
    logic exp_lat;
    do_reset();
    t = $urandom_range(2, 10);
    for (int i = 0; i < 120; i++) begin
      drive({2'($urandom), 2'b11}, (cyc == t) || (cyc == t + 30), (cyc == t) ? 32'h0 : 32'h5);
      @(negedge clk_i);
      exp_led = m_led(cyc, mode_prev);
      exp_lat = m_captured && (m_cap_cycle < cyc);
      n_cmp++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL pass_led cyc=%0d got=%b exp=%b", cyc, led_o, exp_led);
      end
      n_cmp++;
      if (exit_latched_o !== exp_lat) begin
        n_fail++; $display("FAIL pass_latched cyc=%0d got=%b exp=%b", cyc, exit_latched_o, exp_lat);
      end
      n_cmp++;
      if (exit_value_o !== '0) begin
        n_fail++; $display("FAIL pass_value cyc=%0d got=0x%0h exp=0", cyc, exit_value_o);
      end
      advance();
    end
  endtask

  task automatic test_exit_codes();
    logic [EW-1:0] vals [6];
    logic [EW-1:0] v, exp_val;
    logic [NL-1:0] exp_led;
    logic exp_lat;
    int t, t2;
    vals[0] = 32'h3;
    vals[1] = 32'h10;
    vals[2] = 32'h6;
    vals[3] = 32'h7;
    vals[4] = {$urandom} | 32'h1;
    vals[5] = {$urandom} & 32'hFFFF_FFF8 | 32'h8;
    for (int j = 0; j < 6; j++) begin
      do_reset();
      v  = vals[j];
      t  = (j == 2) ? 7 : $urandom_range(1, 12);
      t2 = t + $urandom_range(5, 60);
      for (int i = 0; i < 180; i++) begin
        drive({2'($urandom), 2'b11}, (cyc == t) || (cyc == t2),
              (cyc == t) ? v : ((cyc == t2) ? 32'h5 : $urandom));
        @(negedge clk_i);
        exp_led = m_led(cyc, mode_prev);
        exp_lat = m_captured && (m_cap_cycle < cyc);
        exp_val = exp_lat ? m_cap_val : '0;
        n_cmp++;
        if (led_o !== exp_led) begin
          n_fail++; $display("FAIL code_led val=0x%0h cyc=%0d got=%b exp=%b", v, cyc, led_o, exp_led);
        end
        n_cmp++;
        if (tick_o !== m_tick(cyc)) begin
          n_fail++; $display("FAIL code_tick cyc=%0d got=%b exp=%b", cyc, tick_o, m_tick(cyc));
        end
        n_cmp++;
        if (exit_latched_o !== exp_lat) begin
          n_fail++; $display("FAIL code_latched cyc=%0d got=%b exp=%b", cyc, exit_latched_o, exp_lat);
        end
        n_cmp++;
        if (exit_value_o !== exp_val) begin
          n_fail++; $display("FAIL code_value cyc=%0d got=0x%0h exp=0x%0h", cyc, exit_value_o, exp_val);
        end
        advance();
      end
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    logic [NL-1:0] exp_led;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive(4'b1111, cyc == 3, 32'h3);
      @(negedge clk_i);
      exp_led = m_led(cyc, mode_prev);
      n_cmp++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL midrst_led cyc=%0d got=%b exp=%b", cyc, led_o, exp_led);
      end
      if (m_captured && cyc > m_cap_cycle && m_exit(cyc) && m_exit(cyc + 1)) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL midrst_pulse_wait got=timeout exp=pulse_on");
    end
    @(posedge clk_i);
    #1;
    do_reset();
    drive(4'b1111, 1'b0, '0);
    @(negedge clk_i);
    n_cmp++; if (led_o !== '0) begin n_fail++; $display("FAIL midrst_led0 got=%b exp=00", led_o); end
    n_cmp++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got=%b exp=0", tick_o); end
    n_cmp++; if (exit_latched_o !== 1'b0) begin n_fail++; $display("FAIL midrst_latched got=%b exp=0", exit_latched_o); end
    n_cmp++; if (exit_value_o !== '0) begin n_fail++; $display("FAIL midrst_value got=0x%0h exp=0", exit_value_o); end
    advance();
    for (int i = 0; i < 70; i++) begin
      drive(4'b1111, cyc == 2, 32'h1);
      @(negedge clk_i);
      exp_led = m_led(cyc, mode_prev);
      n_cmp++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL midrst_new_led cyc=%0d got=%b exp=%b", cyc, led_o, exp_led);
      end
      n_cmp++;
      if (exit_value_o !== ((m_captured && m_cap_cycle < cyc) ? 32'h1 : 32'h0)) begin
        n_fail++; $display("FAIL midrst_new_value cyc=%0d got=0x%0h", cyc, exit_value_o);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_modes();
    test_exit_pass();
    test_exit_codes();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
